// File: rtl/pampy_frame_pkg.sv
// Shared constants, FSM encoding and entry-width helper for the call-frame stack.
package pampy_frame_pkg;

  localparam int unsigned DefAddrWidth      = 12;
  localparam int unsigned DefPcWidth        = 12;
  localparam int unsigned DefFrameDepthLog2 = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StPush   = 2'd1,
    StPopRd  = 2'd2,
    StPopCap = 2'd3
  } state_e;

  function automatic int unsigned entry_width(input int unsigned pc_w, input int unsigned addr_w);
    return pc_w + addr_w;
  endfunction

endpackage

// File: rtl/block_call_frame_if.sv
// Request/response bundle between the sequencer and block_call_frame.
// FRAME_HIGH_WATER exists only when CALL_FRAME_WATERMARK_EN is defined.
interface block_call_frame_if #(
  parameter int unsigned ADDR_WIDTH       = pampy_frame_pkg::DefAddrWidth,
  parameter int unsigned PC_WIDTH         = pampy_frame_pkg::DefPcWidth,
  parameter int unsigned FRAME_DEPTH_LOG2 = pampy_frame_pkg::DefFrameDepthLog2
) ();

  logic                        CALL_REQ;
  logic                        RET_REQ;
  logic [PC_WIDTH-1:0]         PC_IN;
  logic [ADDR_WIDTH-1:0]       TOS_IN;
  logic [PC_WIDTH-1:0]         RET_PC_OUT;
  logic [ADDR_WIDTH-1:0]       STACK_TOS_RETURN;
  logic                        DONE;
  logic                        BUSY;
  logic                        FULL;
  logic                        EMPTY;
  logic                        ERR_OVERFLOW;
  logic                        ERR_UNDERFLOW;
`ifdef CALL_FRAME_WATERMARK_EN
  logic [FRAME_DEPTH_LOG2:0]   FRAME_HIGH_WATER;
`endif

  modport master (
    output CALL_REQ, RET_REQ, PC_IN, TOS_IN,
    input  RET_PC_OUT, STACK_TOS_RETURN, DONE, BUSY, FULL, EMPTY, ERR_OVERFLOW, ERR_UNDERFLOW
`ifdef CALL_FRAME_WATERMARK_EN
    , input FRAME_HIGH_WATER
`endif
  );

  modport slave (
    input  CALL_REQ, RET_REQ, PC_IN, TOS_IN,
    output RET_PC_OUT, STACK_TOS_RETURN, DONE, BUSY, FULL, EMPTY, ERR_OVERFLOW, ERR_UNDERFLOW
`ifdef CALL_FRAME_WATERMARK_EN
    , output FRAME_HIGH_WATER
`endif
  );

endinterface

// File: rtl/frame_memory.sv
// Single-port frame store: synchronous write, one-cycle registered read, no reset.
module frame_memory #(
  parameter int unsigned DataWidth = 24,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [2**AddrWidth];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/block_call_frame.sv
// Call/return frame stack saving {PC, TOS} pairs with sticky over/underflow flags.
// Optional FRAME_HIGH_WATER output enabled by CALL_FRAME_WATERMARK_EN.
module block_call_frame
  import pampy_frame_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DefAddrWidth,
  parameter int unsigned PC_WIDTH         = DefPcWidth,
  parameter int unsigned FRAME_DEPTH_LOG2 = DefFrameDepthLog2
) (
  input logic               clk,
  input logic               reset,
  block_call_frame_if.slave bus
);

  localparam int unsigned FpW    = FRAME_DEPTH_LOG2 + 1;
  localparam int unsigned EntryW = entry_width(PC_WIDTH, ADDR_WIDTH);
  localparam int unsigned Depth  = 2 ** FRAME_DEPTH_LOG2;
  localparam logic [FpW-1:0] FpFull = FpW'(Depth);

  state_e                state_q, state_d;
  logic [FpW-1:0]        fp_q, fp_d;
  logic [PC_WIDTH-1:0]   pc_lat_q, pc_lat_d, ret_pc_q, ret_pc_d;
  logic [ADDR_WIDTH-1:0] tos_lat_q, tos_lat_d, ret_tos_q, ret_tos_d;
  logic                  ov_pend_q, ov_pend_d, un_pend_q, un_pend_d;
  logic                  done_q, done_d, err_ov_q, err_ov_d, err_un_q, err_un_d;
  logic                  full, empty, busy, mem_we, mem_re;
  logic [EntryW-1:0]     mem_rdata;

  assign full  = (fp_q == FpFull);
  assign empty = (fp_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Rejected requests reuse StPush as their one-cycle completion slot; the pend bits block the write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.CALL_REQ) begin
          state_d = StPush;
        end else if (bus.RET_REQ) begin
          state_d = empty ? StPush : StPopRd;
        end
      end
      StPush:   state_d = StIdle;
      StPopRd:  state_d = StPopCap;
      StPopCap: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q != StIdle);
    mem_we = (state_q == StPush) && !ov_pend_q && !un_pend_q;
    mem_re = (state_q == StPopRd);
  end

  always_comb begin
    fp_d      = fp_q;
    pc_lat_d  = pc_lat_q;
    tos_lat_d = tos_lat_q;
    ret_pc_d  = ret_pc_q;
    ret_tos_d = ret_tos_q;
    ov_pend_d = 1'b0;
    un_pend_d = 1'b0;
    done_d    = 1'b0;
    err_ov_d  = err_ov_q;
    err_un_d  = err_un_q;
    unique case (state_q)
      StIdle: begin
        if (bus.CALL_REQ) begin
          pc_lat_d  = bus.PC_IN;
          tos_lat_d = bus.TOS_IN;
          ov_pend_d = full;
        end else if (bus.RET_REQ) begin
          if (empty) begin
            un_pend_d = 1'b1;
          end else begin
            fp_d = fp_q - FpW'(1);
          end
        end
      end
      StPush: begin
        done_d = 1'b1;
        if (ov_pend_q) begin
          err_ov_d = 1'b1;
        end else if (un_pend_q) begin
          err_un_d = 1'b1;
        end else begin
          fp_d = fp_q + FpW'(1);
        end
      end
      StPopCap: begin
        done_d    = 1'b1;
        ret_pc_d  = mem_rdata[EntryW-1 -: PC_WIDTH];
        ret_tos_d = mem_rdata[ADDR_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fp_q      <= '0;
      pc_lat_q  <= '0;
      tos_lat_q <= '0;
      ret_pc_q  <= '0;
      ret_tos_q <= '0;
      ov_pend_q <= 1'b0;
      un_pend_q <= 1'b0;
      done_q    <= 1'b0;
      err_ov_q  <= 1'b0;
      err_un_q  <= 1'b0;
    end else begin
      fp_q      <= fp_d;
      pc_lat_q  <= pc_lat_d;
      tos_lat_q <= tos_lat_d;
      ret_pc_q  <= ret_pc_d;
      ret_tos_q <= ret_tos_d;
      ov_pend_q <= ov_pend_d;
      un_pend_q <= un_pend_d;
      done_q    <= done_d;
      err_ov_q  <= err_ov_d;
      err_un_q  <= err_un_d;
    end
  end

  frame_memory #(
    .DataWidth (EntryW),
    .AddrWidth (FRAME_DEPTH_LOG2)
  ) u_frame_memory (
    .clk_i   (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (fp_q[FRAME_DEPTH_LOG2-1:0]),
    .wdata_i ({pc_lat_q, tos_lat_q}),
    .rdata_o (mem_rdata)
  );

  assign bus.RET_PC_OUT       = ret_pc_q;
  assign bus.STACK_TOS_RETURN = ret_tos_q;
  assign bus.DONE             = done_q;
  assign bus.BUSY             = busy;
  assign bus.FULL             = full;
  assign bus.EMPTY            = empty;
  assign bus.ERR_OVERFLOW     = err_ov_q;
  assign bus.ERR_UNDERFLOW    = err_un_q;

`ifdef CALL_FRAME_WATERMARK_EN
  logic [FpW-1:0] hw_q, hw_d;

  assign hw_d = (fp_d > hw_q) ? fp_d : hw_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hw_q <= '0;
    end else begin
      hw_q <= hw_d;
    end
  end

  assign bus.FRAME_HIGH_WATER = hw_q;
`endif

endmodule

// File: tb/tb_block_call_frame.sv
// Directed self-checking bench for block_call_frame at default parameters.
module tb_block_call_frame;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  block_call_frame_if bus_if ();

  block_call_frame dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Drive a request for exactly one rising edge; returns at the negedge after it.
  task automatic drive(input logic call, input logic ret, input logic [11:0] pc,
                       input logic [11:0] tos);
    bus_if.CALL_REQ = call;
    bus_if.RET_REQ  = ret;
    bus_if.PC_IN    = pc;
    bus_if.TOS_IN   = tos;
    @(negedge clk);
    bus_if.CALL_REQ = 1'b0;
    bus_if.RET_REQ  = 1'b0;
  endtask

  task automatic do_call(input logic [11:0] pc, input logic [11:0] tos);
    drive(1'b1, 1'b0, pc, tos);
    @(negedge clk);
  endtask

  task automatic do_ret();
    drive(1'b0, 1'b1, 12'h000, 12'h000);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.CALL_REQ = 1'b0;
    bus_if.RET_REQ  = 1'b0;
    bus_if.PC_IN    = '0;
    bus_if.TOS_IN   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus_if.BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus_if.BUSY); end
    checks++; if (bus_if.DONE !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus_if.DONE); end
    checks++; if (bus_if.EMPTY !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", bus_if.EMPTY); end
    checks++; if (bus_if.FULL !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", bus_if.FULL); end
    checks++; if (bus_if.ERR_OVERFLOW !== 1'b0) begin failures++; $display("FAIL rst_err_ov got=%b exp=0", bus_if.ERR_OVERFLOW); end
    checks++; if (bus_if.ERR_UNDERFLOW !== 1'b0) begin failures++; $display("FAIL rst_err_un got=%b exp=0", bus_if.ERR_UNDERFLOW); end
    checks++; if (bus_if.RET_PC_OUT !== 12'h000) begin failures++; $display("FAIL rst_ret_pc got=%h exp=000", bus_if.RET_PC_OUT); end
    checks++; if (bus_if.STACK_TOS_RETURN !== 12'h000) begin failures++; $display("FAIL rst_tos got=%h exp=000", bus_if.STACK_TOS_RETURN); end
  endtask

  task automatic test_call_ret();
    drive(1'b1, 1'b0, 12'h123, 12'h045);
    checks++; if (bus_if.BUSY !== 1'b1) begin failures++; $display("FAIL call_busy got=%b exp=1", bus_if.BUSY); end
    checks++; if (bus_if.DONE !== 1'b0) begin failures++; $display("FAIL call_done_early got=%b exp=0", bus_if.DONE); end
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b1) begin failures++; $display("FAIL call_done got=%b exp=1", bus_if.DONE); end
    checks++; if (bus_if.EMPTY !== 1'b0) begin failures++; $display("FAIL call_empty got=%b exp=0", bus_if.EMPTY); end
    drive(1'b0, 1'b1, 12'h000, 12'h000);
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b0) begin failures++; $display("FAIL ret_done_k1 got=%b exp=0", bus_if.DONE); end
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b1) begin failures++; $display("FAIL ret_done_k2 got=%b exp=1", bus_if.DONE); end
    checks++; if (bus_if.RET_PC_OUT !== 12'h123) begin failures++; $display("FAIL ret_pc got=%h exp=123", bus_if.RET_PC_OUT); end
    checks++; if (bus_if.STACK_TOS_RETURN !== 12'h045) begin failures++; $display("FAIL ret_tos got=%h exp=045", bus_if.STACK_TOS_RETURN); end
    checks++; if (bus_if.EMPTY !== 1'b1) begin failures++; $display("FAIL ret_empty got=%b exp=1", bus_if.EMPTY); end
  endtask

  task automatic test_lifo();
    logic [11:0] pcs [3];
    logic [11:0] toss [3];
    pcs  = '{12'h010, 12'h020, 12'h030};
    toss = '{12'h001, 12'h002, 12'h003};
    for (int i = 0; i < 3; i++) do_call(pcs[i], toss[i]);
    for (int i = 2; i >= 0; i--) begin
      do_ret();
      checks++; if (bus_if.RET_PC_OUT !== pcs[i]) begin failures++; $display("FAIL lifo_pc[%0d] got=%h exp=%h", i, bus_if.RET_PC_OUT, pcs[i]); end
      checks++; if (bus_if.STACK_TOS_RETURN !== toss[i]) begin failures++; $display("FAIL lifo_tos[%0d] got=%h exp=%h", i, bus_if.STACK_TOS_RETURN, toss[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] exp_pc;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      do_call(12'(256 + i), 12'(i));
      if (i == 14) begin
        checks++; if (bus_if.FULL !== 1'b0) begin failures++; $display("FAIL ovf_full_15 got=%b exp=0", bus_if.FULL); end
      end
    end
    checks++; if (bus_if.FULL !== 1'b1) begin failures++; $display("FAIL ovf_full_16 got=%b exp=1", bus_if.FULL); end
    checks++; if (bus_if.ERR_OVERFLOW !== 1'b0) begin failures++; $display("FAIL ovf_err_early got=%b exp=0", bus_if.ERR_OVERFLOW); end
    drive(1'b1, 1'b0, 12'hFFF, 12'hFFF);
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b1) begin failures++; $display("FAIL ovf_done got=%b exp=1", bus_if.DONE); end
    checks++; if (bus_if.ERR_OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", bus_if.ERR_OVERFLOW); end
    checks++; if (bus_if.FULL !== 1'b1) begin failures++; $display("FAIL ovf_full_17 got=%b exp=1", bus_if.FULL); end
    for (int i = 15; i >= 0; i--) begin
      do_ret();
      exp_pc = 12'(256 + i);
      checks++; if (bus_if.RET_PC_OUT !== exp_pc) begin failures++; $display("FAIL ovf_pop_pc[%0d] got=%h exp=%h", i, bus_if.RET_PC_OUT, exp_pc); end
      checks++; if (bus_if.STACK_TOS_RETURN !== 12'(i)) begin failures++; $display("FAIL ovf_pop_tos[%0d] got=%h exp=%h", i, bus_if.STACK_TOS_RETURN, 12'(i)); end
    end
    checks++; if (bus_if.EMPTY !== 1'b1) begin failures++; $display("FAIL ovf_drained got=%b exp=1", bus_if.EMPTY); end
`ifdef CALL_FRAME_WATERMARK_EN
    checks++; if (bus_if.FRAME_HIGH_WATER !== 5'd16) begin failures++; $display("FAIL hw_16 got=%0d exp=16", bus_if.FRAME_HIGH_WATER); end
`endif
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, 12'h000, 12'h000);
    checks++; if (bus_if.BUSY !== 1'b1) begin failures++; $display("FAIL unf_busy got=%b exp=1", bus_if.BUSY); end
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b1) begin failures++; $display("FAIL unf_done got=%b exp=1", bus_if.DONE); end
    checks++; if (bus_if.ERR_UNDERFLOW !== 1'b1) begin failures++; $display("FAIL unf_err got=%b exp=1", bus_if.ERR_UNDERFLOW); end
    checks++; if (bus_if.RET_PC_OUT !== 12'h100) begin failures++; $display("FAIL unf_pc_hold got=%h exp=100", bus_if.RET_PC_OUT); end
    checks++; if (bus_if.STACK_TOS_RETURN !== 12'h000) begin failures++; $display("FAIL unf_tos_hold got=%h exp=000", bus_if.STACK_TOS_RETURN); end
    checks++; if (bus_if.EMPTY !== 1'b1) begin failures++; $display("FAIL unf_empty got=%b exp=1", bus_if.EMPTY); end
    checks++; if (bus_if.ERR_OVERFLOW !== 1'b1) begin failures++; $display("FAIL unf_ov_sticky got=%b exp=1", bus_if.ERR_OVERFLOW); end
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b0) begin failures++; $display("FAIL unf_done_pulse got=%b exp=0", bus_if.DONE); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    drive(1'b1, 1'b1, 12'h055, 12'h066);
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b1) begin failures++; $display("FAIL sim_done got=%b exp=1", bus_if.DONE); end
    checks++; if (bus_if.EMPTY !== 1'b0) begin failures++; $display("FAIL sim_empty got=%b exp=0", bus_if.EMPTY); end
    checks++; if (bus_if.ERR_UNDERFLOW !== 1'b0) begin failures++; $display("FAIL sim_err_un got=%b exp=0", bus_if.ERR_UNDERFLOW); end
    // Hold RET_REQ high through POP_RD; only the first one may take effect.
    bus_if.RET_REQ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_if.RET_REQ = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b1) begin failures++; $display("FAIL sim_ret_done got=%b exp=1", bus_if.DONE); end
    checks++; if (bus_if.RET_PC_OUT !== 12'h055) begin failures++; $display("FAIL sim_ret_pc got=%h exp=055", bus_if.RET_PC_OUT); end
    checks++; if (bus_if.STACK_TOS_RETURN !== 12'h066) begin failures++; $display("FAIL sim_ret_tos got=%h exp=066", bus_if.STACK_TOS_RETURN); end
    checks++; if (bus_if.EMPTY !== 1'b1) begin failures++; $display("FAIL sim_fp1 got=%b exp=1", bus_if.EMPTY); end
    @(negedge clk);
    checks++; if (bus_if.BUSY !== 1'b0) begin failures++; $display("FAIL sim_ignored_busy got=%b exp=0", bus_if.BUSY); end
    checks++; if (bus_if.ERR_UNDERFLOW !== 1'b0) begin failures++; $display("FAIL sim_ignored_err got=%b exp=0", bus_if.ERR_UNDERFLOW); end
  endtask

  task automatic test_reset_in_pop();
    do_call(12'h077, 12'h088);
    drive(1'b0, 1'b1, 12'h000, 12'h000);
    checks++; if (bus_if.BUSY !== 1'b1) begin failures++; $display("FAIL rpop_busy got=%b exp=1", bus_if.BUSY); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus_if.BUSY !== 1'b0) begin failures++; $display("FAIL rpop_idle got=%b exp=0", bus_if.BUSY); end
    checks++; if (bus_if.DONE !== 1'b0) begin failures++; $display("FAIL rpop_done got=%b exp=0", bus_if.DONE); end
    checks++; if (bus_if.EMPTY !== 1'b1) begin failures++; $display("FAIL rpop_empty got=%b exp=1", bus_if.EMPTY); end
    checks++; if (bus_if.RET_PC_OUT !== 12'h000) begin failures++; $display("FAIL rpop_pc got=%h exp=000", bus_if.RET_PC_OUT); end
    checks++; if (bus_if.STACK_TOS_RETURN !== 12'h000) begin failures++; $display("FAIL rpop_tos got=%h exp=000", bus_if.STACK_TOS_RETURN); end
`ifdef CALL_FRAME_WATERMARK_EN
    checks++; if (bus_if.FRAME_HIGH_WATER !== 5'd0) begin failures++; $display("FAIL rpop_hw got=%0d exp=0", bus_if.FRAME_HIGH_WATER); end
`endif
    @(negedge clk);
    checks++; if (bus_if.DONE !== 1'b0) begin failures++; $display("FAIL rpop_no_late_done got=%b exp=0", bus_if.DONE); end
    checks++; if (bus_if.RET_PC_OUT !== 12'h000) begin failures++; $display("FAIL rpop_pc_late got=%h exp=000", bus_if.RET_PC_OUT); end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_lifo();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_reset_in_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
